fatori_mon_voter_q: RTL and testbench
=====================================

FATORI_MON_VOTER_Q -- requirements
Module: fatori_mon_voter_q

Interface
REQ-001 Parameter W, default 32: replica word width, 1..1024.
REQ-002 Parameter N, default 3: replica count, 3..8.
REQ-003 Parameter M, default 2: agreement threshold, N/2 < M <= N.
REQ-004 Parameter QUAR_TH, default 4: consecutive-mismatch count that quarantines a replica, 1..2^CNT_W-1.
REQ-005 Parameter CNT_W, default 4: width of the per-replica mismatch counters.
REQ-006 Parameter HOLD, default 0: 1 = hold the last voted bit on no-majority; 0 = pass the lowest-index active replica's bit.
REQ-007 Parameter REG_OUT, default 0: 1 = register all outputs, adding 1 cycle of latency.
REQ-008 Port clk_i, input, 1: the only clock, rising edge.
REQ-009 Port rst_i, input, 1: reset, asynchronous, active-high.
REQ-010 Port replicas_i, input, N x W: replica words, index 0..N-1.
REQ-011 Port readmit_i, input, 1: one-cycle pulse that clears all quarantine state and counters.
REQ-012 Port y_o, output, W: voted word.
REQ-013 Port min_err_o, output, 1: at least one active replica disagrees with y_o while a majority exists.
REQ-014 Port maj_err_o, output, 1: at least one bit has no M-agreement among active replicas.
REQ-015 Port scrub_occurred_o, output, 1: pulse, equal to min_err and not maj_err, for the same vote.
REQ-016 Port quar_o, output, N: sticky per-replica quarantine flags.
REQ-017 Port maj_sticky_o, output, 1: set on any maj_err; cleared only by reset.
REQ-018 Port err_cnt_o, output, 16: saturating count of cycles with min_err_o high.

Function
REQ-019 Only active replicas (quar_o[i]=0) participate in voting, mismatch detection and min_err.
REQ-020 Per bit b, the voted bit is 1 if the ones-count among active replicas is >= M, and 0 if the zeros-count is >= M.
REQ-021 Per bit b with neither count >= M, the bit is undecided: maj_err is set and y_o[b] follows HOLD per REQ-006; the HOLD register updates only on decided bits.
REQ-022 Replica i is mismatched in a cycle when it is active, maj_err=0 and replicas_i[i] != voted word.
REQ-023 The mismatch counter for i increments (saturating at 2^CNT_W-1) when i is mismatched, clears when active and matching, and holds when maj_err=1.
REQ-024 A replica whose counter reaches QUAR_TH sets quar_o[i] on the next edge; the flag is sticky until readmit_i or reset.
REQ-025 Quarantine is blocked if it would leave fewer than M active replicas.
REQ-026 When several replicas qualify for quarantine in the same cycle, the lowest index is quarantined first; the others retry next cycle under REQ-025.
REQ-027 readmit_i clears every quar_o bit and every counter on the next edge.
REQ-028 readmit_i takes priority over a simultaneous quarantine or counter increment.
REQ-029 REG_OUT=0: y_o, min_err_o, maj_err_o and scrub_occurred_o are combinational from replicas_i and current state, with 0-cycle latency.
REQ-030 REG_OUT=1: those outputs are registered and appear 1 cycle after the inputs.
REQ-031 quar_o, maj_sticky_o and err_cnt_o are always registered.
REQ-032 err_cnt_o increments by 1 per min_err cycle and saturates at 16'hFFFF.
REQ-033 min_err_o and maj_err_o can never both be 1, since maj_err masks min_err.

Reset
REQ-034 While rst_i=1, asynchronously: y_o=0, HOLD register=0, all counters=0, quar_o=0, maj_sticky_o=0, err_cnt_o=0, min_err_o=0, maj_err_o=0, scrub_occurred_o=0; REG_OUT=0 outputs follow the inputs with the zeroed state.
REQ-035 Reset asserted mid-quarantine or mid-count discards all state; the first cycle after release votes with all N replicas active.

Verification (N=3, M=2, W=8, QUAR_TH=3, HOLD=0, REG_OUT=0 unless stated)
REQ-036 Replicas {A5,A5,A5} -> y_o=A5, min_err=0, maj_err=0, err_cnt unchanged.
REQ-037 Replicas {A5,A5,5A} for 3 cycles -> y_o=A5, min_err=1 and scrub_occurred=1 each cycle, quar_o=3'b100 after the 3rd edge, err_cnt=3; then {A5,A5,00} -> min_err=0.
REQ-038 Replica 2 quarantined, then {A5,5A,xx} -> maj_err=1 on differing bits, y_o=A5 (lowest active), maj_sticky_o=1, replica 1 not quarantined (REQ-025).
REQ-039 HOLD=1: y_o=A5, then {00,FF,xx} with replica 2 quarantined -> y_o stays A5; REG_OUT=1 -> same values 1 cycle later.
REQ-040 quar_o=3'b100, readmit_i pulse on the same cycle replica 0 reaches QUAR_TH -> quar_o=000 and all counters 0 next cycle.
REQ-041 rst_i asserted mid-count (counter=2) -> all outputs 0 immediately; after release a single mismatch gives counter 1, no quarantine.

Source files
------------

// File: rtl/fatori_mon_voter_q.sv
// N-way bitwise M-of-N voter with per-replica mismatch tracking and quarantine.
// Voting, mismatch detection and min_err only consider replicas that are not quarantined.
module fatori_mon_voter_q #(
  parameter int unsigned W       = 32,
  parameter int unsigned N       = 3,
  parameter int unsigned M       = 2,
  parameter int unsigned QUAR_TH = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned HOLD    = 0,
  parameter int unsigned REG_OUT = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N*W-1:0] replicas_i,
  input  logic           readmit_i,
  output logic [W-1:0]   y_o,
  output logic           min_err_o,
  output logic           maj_err_o,
  output logic           scrub_occurred_o,
  output logic [N-1:0]   quar_o,
  output logic           maj_sticky_o,
  output logic [15:0]    err_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] QuarTh = CNT_W'(QUAR_TH);

  logic [N-1:0]     quar_q, quar_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [W-1:0]     hold_q, hold_d;
  logic             sticky_q;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic [W-1:0]     low_word;
  logic             low_found;
  logic [W-1:0]     vote;
  logic [W-1:0]     undec;
  logic [N-1:0]     mismatch;
  logic             maj_err;
  logic             min_err;
  logic             scrub;
  logic             picked;

  // Fallback word for undecided bits when not holding.
  always_comb begin
    low_word  = '0;
    low_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!quar_q[i] && !low_found) begin
        low_word  = replicas_i[i*W +: W];
        low_found = 1'b1;
      end
    end
  end

  always_comb begin : vote_c
    int unsigned ones;
    int unsigned zeros;
    ones  = 0;
    zeros = 0;
    vote  = '0;
    undec = '0;
    for (int b = 0; b < W; b++) begin
      ones  = 0;
      zeros = 0;
      for (int i = 0; i < N; i++) begin
        if (!quar_q[i]) begin
          if (replicas_i[i*W + b]) ones++;
          else                     zeros++;
        end
      end
      if (ones >= M) begin
        vote[b] = 1'b1;
      end else if (zeros >= M) begin
        vote[b] = 1'b0;
      end else begin
        undec[b] = 1'b1;
        vote[b]  = (HOLD != 0) ? hold_q[b] : low_word[b];
      end
    end
  end

  assign maj_err = |undec;

  always_comb begin
    mismatch = '0;
    for (int i = 0; i < N; i++) begin
      mismatch[i] = !quar_q[i] && !maj_err && (replicas_i[i*W +: W] != vote);
    end
  end

  assign min_err = |mismatch;
  assign scrub   = min_err & ~maj_err;
  assign hold_d  = (vote & ~undec) | (hold_q & undec);

  always_comb begin : quar_c
    int unsigned n_active;
    n_active = 0;
    for (int i = 0; i < N; i++) begin
      if (!quar_q[i]) n_active++;
    end
    quar_d = quar_q;
    picked = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (readmit_i) begin
        cnt_d[i] = '0;
      end else if (!quar_q[i] && !maj_err) begin
        if (mismatch[i]) cnt_d[i] = (cnt_q[i] == CntMax) ? cnt_q[i] : cnt_q[i] + 1'b1;
        else             cnt_d[i] = '0;
      end
    end
    // One quarantine per cycle, lowest index first, never dropping below M voters.
    if (readmit_i) begin
      quar_d = '0;
    end else if (n_active > M) begin
      for (int i = 0; i < N; i++) begin
        if (!quar_q[i] && (cnt_d[i] >= QuarTh) && !picked) begin
          quar_d[i] = 1'b1;
          picked    = 1'b1;
        end
      end
    end
  end

  assign err_cnt_d = (min_err && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quar_q    <= '0;
      hold_q    <= '0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      quar_q    <= quar_d;
      hold_q    <= hold_d;
      sticky_q  <= sticky_q | maj_err;
      err_cnt_q <= err_cnt_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign quar_o       = quar_q;
  assign maj_sticky_o = sticky_q;
  assign err_cnt_o    = err_cnt_q;

  if (REG_OUT != 0) begin : g_reg_out
    logic [W-1:0] y_q;
    logic         min_q, maj_q, scrub_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        y_q     <= '0;
        min_q   <= 1'b0;
        maj_q   <= 1'b0;
        scrub_q <= 1'b0;
      end else begin
        y_q     <= vote;
        min_q   <= min_err;
        maj_q   <= maj_err;
        scrub_q <= scrub;
      end
    end
    assign y_o              = y_q;
    assign min_err_o        = min_q;
    assign maj_err_o        = maj_q;
    assign scrub_occurred_o = scrub_q;
  end else begin : g_comb_out
    assign y_o              = vote;
    assign min_err_o        = min_err;
    assign maj_err_o        = maj_err;
    assign scrub_occurred_o = scrub;
  end

endmodule

// File: tb/tb_fatori_mon_voter_q.sv
// Bench for fatori_mon_voter_q: combinational DUT checked in-cycle from a vector table,
// a HOLD=1/REG_OUT=1 twin checked one cycle later through a scoreboard queue.
module tb_fatori_mon_voter_q;

  localparam int unsigned W = 8;
  localparam int unsigned N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] replicas;
  logic           readmit;

  logic [W-1:0] y_a, y_b;
  logic         min_a, min_b, maj_a, maj_b, scr_a, scr_b, stk_a, stk_b;
  logic [N-1:0] quar_a, quar_b;
  logic [15:0]  ec_a, ec_b;

  always #5 clk = ~clk;

  fatori_mon_voter_q #(
    .W(W), .N(N), .M(2), .QUAR_TH(3), .CNT_W(4), .HOLD(0), .REG_OUT(0)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .replicas_i(replicas), .readmit_i(readmit),
    .y_o(y_a), .min_err_o(min_a), .maj_err_o(maj_a), .scrub_occurred_o(scr_a),
    .quar_o(quar_a), .maj_sticky_o(stk_a), .err_cnt_o(ec_a)
  );

  fatori_mon_voter_q #(
    .W(W), .N(N), .M(2), .QUAR_TH(3), .CNT_W(4), .HOLD(1), .REG_OUT(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .replicas_i(replicas), .readmit_i(readmit),
    .y_o(y_b), .min_err_o(min_b), .maj_err_o(maj_b), .scrub_occurred_o(scr_b),
    .quar_o(quar_b), .maj_sticky_o(stk_b), .err_cnt_o(ec_b)
  );

  typedef struct {
    logic [7:0]  r0, r1, r2;
    logic        readmit;
    logic [7:0]  y;       // HOLD=0 voted word
    logic [7:0]  yh;      // HOLD=1 voted word
    logic        mn, mj;
    logic [2:0]  quar;    // after the edge
    logic [15:0] err;     // after the edge
    logic        sticky;  // after the edge
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic       mn, mj;
  } sb_t;

  sb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  step_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, exp);
    end
  endtask

  // Called at posedge+1; leaves at the following posedge+1.
  task automatic step(input vec_t v);
    sb_t e;
    step_no++;
    replicas = {v.r2, v.r1, v.r0};
    readmit  = v.readmit;
    #3;
    chk("y", 32'(y_a), 32'(v.y));
    chk("min_err", 32'(min_a), 32'(v.mn));
    chk("maj_err", 32'(maj_a), 32'(v.mj));
    chk("scrub", 32'(scr_a), 32'(v.mn & ~v.mj));
    chk("min_maj_excl", 32'(min_a & maj_a), 32'd0);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("reg_y", 32'(y_b), 32'(e.y));
      chk("reg_min_err", 32'(min_b), 32'(e.mn));
      chk("reg_maj_err", 32'(maj_b), 32'(e.mj));
      chk("reg_scrub", 32'(scr_b), 32'(e.mn & ~e.mj));
    end
    sb_q.push_back('{y: v.yh, mn: v.mn, mj: v.mj});
    @(posedge clk);
    #1;
    readmit = 1'b0;
    chk("quar", 32'(quar_a), 32'(v.quar));
    chk("quar_reg", 32'(quar_b), 32'(v.quar));
    chk("err_cnt", 32'(ec_a), 32'(v.err));
    chk("err_cnt_reg", 32'(ec_b), 32'(v.err));
    chk("maj_sticky", 32'(stk_a), 32'(v.sticky));
    chk("maj_sticky_reg", 32'(stk_b), 32'(v.sticky));
  endtask

  // Asynchronous reset pulse between edges; state must clear without a clock.
  task automatic pulse_reset();
    step_no++;
    rst      = 1'b1;
    replicas = '0;
    readmit  = 1'b0;
    #1;
    chk("rst_quar", 32'(quar_a), 32'd0);
    chk("rst_err_cnt", 32'(ec_a), 32'd0);
    chk("rst_sticky", 32'(stk_a), 32'd0);
    chk("rst_y", 32'(y_a), 32'd0);
    chk("rst_min", 32'(min_a), 32'd0);
    chk("rst_maj", 32'(maj_a), 32'd0);
    chk("rst_reg_y", 32'(y_b), 32'd0);
    chk("rst_reg_min", 32'(min_b), 32'd0);
    chk("rst_reg_maj", 32'(maj_b), 32'd0);
    chk("rst_reg_scrub", 32'(scr_b), 32'd0);
    chk("rst_reg_quar", 32'(quar_b), 32'd0);
    #1;
    rst = 1'b0;
    sb_q.delete();
    sb_q.push_back('{y: 8'h00, mn: 1'b0, mj: 1'b0});
  endtask

  vec_t tbl[23];
  vec_t seq[6];

  initial begin
    //           r0     r1     r2     rdm   y      yh     mn    mj    quar    err  stk
    tbl[0]  = '{8'hA5, 8'hA5, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b000, 16'd0, 1'b0};
    tbl[1]  = '{8'hA5, 8'hA5, 8'h5A, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b000, 16'd1, 1'b0};
    tbl[2]  = '{8'hA5, 8'hA5, 8'h5A, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b000, 16'd2, 1'b0};
    tbl[3]  = '{8'hA5, 8'hA5, 8'h5A, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b100, 16'd3, 1'b0};
    tbl[4]  = '{8'hA5, 8'hA5, 8'h00, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b100, 16'd3, 1'b0};
    tbl[5]  = '{8'hA5, 8'h5A, 8'h00, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b1, 3'b100, 16'd3, 1'b1};
    tbl[6]  = '{8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, 3'b100, 16'd3, 1'b1};
    tbl[7]  = '{8'h5A, 8'h5A, 8'hA5, 1'b0, 8'h5A, 8'h5A, 1'b0, 1'b0, 3'b100, 16'd3, 1'b1};
    tbl[8]  = '{8'h3C, 8'hC3, 8'h00, 1'b0, 8'h3C, 8'h5A, 1'b0, 1'b1, 3'b100, 16'd3, 1'b1};
    tbl[9]  = '{8'hA5, 8'hA5, 8'hA5, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b000, 16'd3, 1'b1};
    tbl[10] = '{8'h5A, 8'hA5, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b000, 16'd4, 1'b1};
    tbl[11] = '{8'h5A, 8'hA5, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b000, 16'd5, 1'b1};
    // Replica 0 hits the threshold on this edge, but readmit wins.
    tbl[12] = '{8'h5A, 8'hA5, 8'hA5, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b000, 16'd6, 1'b1};
    tbl[13] = '{8'h5A, 8'hA5, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b000, 16'd7, 1'b1};
    tbl[14] = '{8'h5A, 8'hA5, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b000, 16'd8, 1'b1};
    tbl[15] = '{8'h5A, 8'hA5, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b001, 16'd9, 1'b1};
    tbl[16] = '{8'h5A, 8'hA5, 8'h5A, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b1, 3'b001, 16'd9, 1'b1};
    tbl[17] = '{8'hA5, 8'hA5, 8'hA5, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b000, 16'd9, 1'b1};
    // Replicas 1 and 2 both qualify together: 1 goes first, 2 is then blocked.
    tbl[18] = '{8'hFF, 8'h0F, 8'hF0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 3'b000, 16'd10, 1'b1};
    tbl[19] = '{8'hFF, 8'h0F, 8'hF0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 3'b000, 16'd11, 1'b1};
    tbl[20] = '{8'hFF, 8'h0F, 8'hF0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 3'b010, 16'd12, 1'b1};
    tbl[21] = '{8'hFF, 8'h0F, 8'hF0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 3'b010, 16'd12, 1'b1};
    tbl[22] = '{8'hFF, 8'h0F, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 3'b010, 16'd12, 1'b1};

    // Build a mid-count state, reset, then confirm counting restarts from zero.
    seq[0]  = '{8'hA5, 8'hA5, 8'hA5, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b000, 16'd12, 1'b1};
    seq[1]  = '{8'hA5, 8'hA5, 8'h5A, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b000, 16'd13, 1'b1};
    seq[2]  = '{8'hA5, 8'hA5, 8'h5A, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b000, 16'd14, 1'b1};
    seq[3]  = '{8'hA5, 8'hA5, 8'h5A, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b000, 16'd1, 1'b0};
    seq[4]  = '{8'hA5, 8'hA5, 8'h5A, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b000, 16'd2, 1'b0};
    seq[5]  = '{8'hA5, 8'hA5, 8'h5A, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b100, 16'd3, 1'b0};

    rst      = 1'b1;
    replicas = '0;
    readmit  = 1'b0;
    @(posedge clk);
    #1;
    pulse_reset();

    for (int k = 0; k < 23; k++) step(tbl[k]);

    for (int k = 0; k < 3; k++) step(seq[k]);
    pulse_reset();
    for (int k = 3; k < 6; k++) step(seq[k]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
